// File: rtl/rom_boot_sequencer_pkg.sv
// ============================================================================
// Module   : rom_boot_sequencer_pkg
// Purpose  : Shared state encoding, default geometry and small helpers for
//            the boot-ROM copy sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_boot_sequencer_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COPY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // The ROM port is free for debug only when no copy owns it.
  function automatic logic is_quiescent(input seq_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rom_boot_sequencer_if.sv
// ============================================================================
// Module   : rom_boot_sequencer_if
// Purpose  : Bundles the ROM read port, IMEM write port, debug read port and
//            CPU-facing status of the boot sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rom_boot_sequencer_if
  import rom_boot_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_instr;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_valid;
  logic [31:0]       dbg_rdata;
  logic              cpu_stall;
  logic              done;
  logic [31:0]       checksum;

  // Sequencer side: owns the ROM address and every status output.
  modport master (
    input  start, rom_instr, dbg_req, dbg_addr,
    output rom_addr, imem_we, imem_waddr, imem_wdata,
    output dbg_gnt, dbg_valid, dbg_rdata, cpu_stall, done, checksum
  );

  // Environment side: ROM, IMEM, CPU and debugger.
  modport slave (
    output start, rom_instr, dbg_req, dbg_addr,
    input  rom_addr, imem_we, imem_waddr, imem_wdata,
    input  dbg_gnt, dbg_valid, dbg_rdata, cpu_stall, done, checksum
  );

endinterface

`default_nettype wire

// File: rtl/rom_boot_sequencer_arb.sv
// ============================================================================
// Module   : rom_port_arb
// Purpose  : Combinational owner of the shared ROM address bus. The copy
//            engine always wins; debug is granted only when the sequencer is
//            idle or finished and no start is arriving this cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_port_arb
  import rom_boot_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  seq_state_t        state,
  input  logic              start,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [ADDR_W-1:0] cnt,
  output logic              dbg_gnt,
  output logic [ADDR_W-1:0] rom_addr
);

  // start beats a debug request arriving in the same cycle.
  always_comb begin
    dbg_gnt = dbg_req & is_quiescent(state) & ~start;
  end

  // Address mux: copy counter, then granted debug address, else zero.
  always_comb begin
    rom_addr = '0;
    if (state == ST_COPY) begin
      rom_addr = cnt;
    end else if (dbg_gnt) begin
      rom_addr = dbg_addr;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rom_boot_sequencer.sv
// ============================================================================
// Module   : rom_boot_sequencer
// Purpose  : Copies the test-program ROM into IMEM after start, accumulating
//            a checksum and stalling the CPU until IMEM is final. A debug
//            read port shares the ROM address bus when no copy is running.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_boot_sequencer
  import rom_boot_sequencer_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int IMEM_BASE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  rom_boot_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(IMEM_BASE);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              gnt;
  logic [ADDR_W-1:0] rom_addr;

  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [31:0]       checksum;
  logic              done;
  logic              cpu_stall;
  logic              dbg_valid;
  logic [31:0]       dbg_rdata;

  rom_port_arb #(
    .ADDR_W (ADDR_W)
  ) u_arb (
    .state    (state),
    .start    (bus.start),
    .dbg_req  (bus.dbg_req),
    .dbg_addr (bus.dbg_addr),
    .cnt      (cnt),
    .dbg_gnt  (gnt),
    .rom_addr (rom_addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is ignored while a copy is in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_COPY;
      ST_COPY:  if (cnt == LAST_CNT) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  if (bus.start) state_nxt = ST_COPY;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Copy datapath: counter, IMEM write port, checksum and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      checksum   <= '0;
      done       <= 1'b0;
      cpu_stall  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            cnt      <= '0;
            checksum <= '0;
          end
        end
        ST_COPY: begin
          imem_wdata <= bus.rom_instr;
          imem_waddr <= BASE + cnt;
          imem_we    <= 1'b1;
          checksum   <= checksum + bus.rom_instr;
          cnt        <= cnt + 1'b1;
        end
        ST_DRAIN: begin
          imem_we   <= 1'b0;
          done      <= 1'b1;
          cpu_stall <= 1'b0;
        end
        ST_DONE: begin
          if (bus.start) begin
            done      <= 1'b0;
            cpu_stall <= 1'b1;
            checksum  <= '0;
            cnt       <= '0;
          end
        end
        default: begin
          imem_we <= 1'b0;
        end
      endcase
    end
  end

  // Debug read capture: ROM data sampled on the granted cycle, held after.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_valid <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_valid <= gnt;
      if (gnt) begin
        dbg_rdata <= bus.rom_instr;
      end
    end
  end

  assign bus.rom_addr   = rom_addr;
  assign bus.dbg_gnt    = gnt;
  assign bus.imem_we    = imem_we;
  assign bus.imem_waddr = imem_waddr;
  assign bus.imem_wdata = imem_wdata;
  assign bus.checksum   = checksum;
  assign bus.done       = done;
  assign bus.cpu_stall  = cpu_stall;
  assign bus.dbg_valid  = dbg_valid;
  assign bus.dbg_rdata  = dbg_rdata;

endmodule

`default_nettype wire

// File: tb/tb_rom_boot_sequencer.sv
// ============================================================================
// Module   : tb_rom_boot_sequencer
// Purpose  : Self-checking bench for rom_boot_sequencer. Two instances: one
//            with IMEM_BASE = 0 and one with IMEM_BASE = 4. Expected IMEM
//            traffic and checksums come from a write-list model built from
//            the ROM contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_boot_sequencer;

  localparam int AW    = 5;
  localparam int DEPTH = 31;
  localparam int DONE_CYC = DEPTH + 2;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rom_boot_sequencer_if #(.ADDR_W(AW)) bus0 ();
  rom_boot_sequencer_if #(.ADDR_W(AW)) bus4 ();

  // Test ROM: word[i] = i+1 below 31, unknown above.
  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    if (a < 5'd31) return 32'(a) + 32'd1;
    return 'x;
  endfunction

  assign bus0.rom_instr = rom_word(bus0.rom_addr);
  assign bus4.rom_instr = rom_word(bus4.rom_addr);

  rom_boot_sequencer #(.ADDR_W(AW), .DEPTH(DEPTH), .IMEM_BASE(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.master)
  );

  rom_boot_sequencer #(.ADDR_W(AW), .DEPTH(DEPTH), .IMEM_BASE(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.master)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full copy on instance 0 with per-cycle checks. Optional debug request
  // raised at cycle dbg_at (or together with start), optional ignored start
  // pulse at cycle restart_at.
  task automatic run_copy(input string tag, input int dbg_at, input logic [AW-1:0] dbg_a,
                          input int restart_at, input bit req_with_start);
    wr_t         q[$];
    wr_t         rec;
    logic [31:0] exp_sum = 32'd0;
    bit          req_on  = req_with_start;
    for (int k = 0; k < DEPTH; k++) q.push_back('{a: AW'(k), d: 32'(k + 1)});

    bus0.start    = 1'b1;
    bus0.dbg_req  = req_with_start;
    bus0.dbg_addr = dbg_a;
    #1;
    if (req_with_start) begin
      n_checks++;
      if (bus0.dbg_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL %s gnt_with_start got %b exp 0", tag, bus0.dbg_gnt);
      end
    end
    step();
    bus0.start = 1'b0;

    for (int c = 1; c <= DONE_CYC; c++) begin
      if (c >= 2 && c <= DEPTH + 1) begin
        rec = q.pop_front();
        exp_sum += rec.d;
        n_checks++;
        if (bus0.imem_we !== 1'b1 || bus0.imem_waddr !== rec.a || bus0.imem_wdata !== rec.d) begin
          n_fail++;
          $display("FAIL %s write c=%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=%h",
                   tag, c, bus0.imem_we, bus0.imem_waddr, bus0.imem_wdata, rec.a, rec.d);
        end
      end else begin
        n_checks++;
        if (bus0.imem_we !== 1'b0) begin
          n_fail++;
          $display("FAIL %s we_idle c=%0d got %b exp 0", tag, c, bus0.imem_we);
        end
      end
      n_checks++;
      if (bus0.checksum !== exp_sum) begin
        n_fail++;
        $display("FAIL %s checksum c=%0d got %h exp %h", tag, c, bus0.checksum, exp_sum);
      end
      n_checks++;
      if (bus0.done !== (c == DONE_CYC) || bus0.cpu_stall !== (c != DONE_CYC)) begin
        n_fail++;
        $display("FAIL %s status c=%0d got done=%b stall=%b exp done=%b stall=%b",
                 tag, c, bus0.done, bus0.cpu_stall, c == DONE_CYC, c != DONE_CYC);
      end

      if (c == dbg_at) begin
        req_on        = 1'b1;
        bus0.dbg_req  = 1'b1;
        bus0.dbg_addr = dbg_a;
      end
      bus0.start = (c == restart_at);
      #1;

      if (c < DONE_CYC) begin
        n_checks++;
        if (bus0.dbg_gnt !== 1'b0 || bus0.rom_addr !== ((c <= DEPTH) ? AW'(c - 1) : AW'(0))) begin
          n_fail++;
          $display("FAIL %s rom_port c=%0d got gnt=%b addr=%0d", tag, c, bus0.dbg_gnt, bus0.rom_addr);
        end
        step();
      end else if (req_on) begin
        n_checks++;
        if (bus0.dbg_gnt !== 1'b1 || bus0.rom_addr !== dbg_a) begin
          n_fail++;
          $display("FAIL %s first_done_gnt got gnt=%b addr=%0d exp gnt=1 addr=%0d",
                   tag, bus0.dbg_gnt, bus0.rom_addr, dbg_a);
        end
      end
    end

    n_checks++;
    if (exp_sum !== 32'h0000_01F0) begin
      n_fail++;
      $display("FAIL %s model_sum got %h exp 000001f0", tag, exp_sum);
    end

    if (req_on) begin
      step();
      bus0.dbg_req = 1'b0;
      n_checks++;
      if (bus0.dbg_valid !== 1'b1 || bus0.dbg_rdata !== 32'(dbg_a) + 32'd1) begin
        n_fail++;
        $display("FAIL %s dbg_read got v=%b d=%h exp v=1 d=%h",
                 tag, bus0.dbg_valid, bus0.dbg_rdata, 32'(dbg_a) + 32'd1);
      end
      n_checks++;
      if (bus0.done !== 1'b1 || bus0.cpu_stall !== 1'b0 || bus0.checksum !== exp_sum || bus0.imem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL %s dbg_side_effect got done=%b stall=%b sum=%h we=%b",
                 tag, bus0.done, bus0.cpu_stall, bus0.checksum, bus0.imem_we);
      end
      step();
      n_checks++;
      if (bus0.dbg_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s dbg_valid_pulse got %b exp 0", tag, bus0.dbg_valid);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (bus0.cpu_stall !== 1'b1 || bus4.cpu_stall !== 1'b1 || bus0.done !== 1'b0 || bus0.imem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status got stall=%b/%b done=%b we=%b", bus0.cpu_stall, bus4.cpu_stall, bus0.done, bus0.imem_we);
    end
    n_checks++;
    if (bus0.imem_waddr !== '0 || bus0.imem_wdata !== '0 || bus0.checksum !== '0 ||
        bus0.dbg_valid !== 1'b0 || bus0.dbg_rdata !== '0 || bus0.dbg_gnt !== 1'b0 || bus0.rom_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_data got a=%0d d=%h sum=%h v=%b rd=%h gnt=%b ra=%0d", bus0.imem_waddr, bus0.imem_wdata,
               bus0.checksum, bus0.dbg_valid, bus0.dbg_rdata, bus0.dbg_gnt, bus0.rom_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_copy();
    int gap = $urandom_range(0, 3);
    for (int i = 0; i < gap; i++) step();
    run_copy("basic", -1, '0, -1, 1'b0);
  endtask

  task automatic test_base_offset();
    wr_t         q[$];
    wr_t         rec;
    logic [31:0] exp_sum = 32'd0;
    for (int k = 0; k < DEPTH; k++) q.push_back('{a: AW'((4 + k) % 32), d: 32'(k + 1)});
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    for (int c = 1; c <= DONE_CYC; c++) begin
      if (c >= 2 && c <= DEPTH + 1) begin
        rec = q.pop_front();
        exp_sum += rec.d;
        n_checks++;
        if (bus4.imem_we !== 1'b1 || bus4.imem_waddr !== rec.a || bus4.imem_wdata !== rec.d ||
            $isunknown(bus4.imem_waddr) || bus4.checksum !== exp_sum) begin
          n_fail++;
          $display("FAIL base4_write c=%0d got a=%0d d=%h sum=%h exp a=%0d d=%h sum=%h", c,
                   bus4.imem_waddr, bus4.imem_wdata, bus4.checksum, rec.a, rec.d, exp_sum);
        end
      end
      if (c == DEPTH + 1) begin
        n_checks++;
        if (bus4.imem_waddr !== 5'd2 || bus4.imem_wdata !== 32'd31) begin
          n_fail++;
          $display("FAIL base4_last got a=%0d d=%h exp a=2 d=1f", bus4.imem_waddr, bus4.imem_wdata);
        end
      end
      if (c < DONE_CYC) step();
    end
    n_checks++;
    if (bus4.done !== 1'b1 || bus4.cpu_stall !== 1'b0 || bus4.imem_we !== 1'b0 || bus4.checksum !== 32'h1F0) begin
      n_fail++;
      $display("FAIL base4_done got done=%b stall=%b we=%b sum=%h", bus4.done, bus4.cpu_stall, bus4.imem_we, bus4.checksum);
    end
  endtask

  // Instance 0 is in DONE: one grant per cycle with changing addresses.
  task automatic test_back_to_back();
    int            n = $urandom_range(4, 8);
    logic [AW-1:0] a;
    logic [AW-1:0] prev = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        n_checks++;
        if (bus0.dbg_valid !== 1'b1 || bus0.dbg_rdata !== 32'(prev) + 32'd1) begin
          n_fail++;
          $display("FAIL b2b_data i=%0d got v=%b d=%h exp d=%h", i, bus0.dbg_valid, bus0.dbg_rdata, 32'(prev) + 32'd1);
        end
      end
      a = AW'($urandom_range(0, 30));
      bus0.dbg_req  = 1'b1;
      bus0.dbg_addr = a;
      #1;
      n_checks++;
      if (bus0.dbg_gnt !== 1'b1 || bus0.rom_addr !== a) begin
        n_fail++;
        $display("FAIL b2b_gnt i=%0d got gnt=%b addr=%0d exp addr=%0d", i, bus0.dbg_gnt, bus0.rom_addr, a);
      end
      prev = a;
      step();
    end
    bus0.dbg_req = 1'b0;
    n_checks++;
    if (bus0.dbg_valid !== 1'b1 || bus0.dbg_rdata !== 32'(prev) + 32'd1 || bus0.done !== 1'b1 ||
        bus0.cpu_stall !== 1'b0 || bus0.checksum !== 32'h1F0 || bus0.imem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_last got v=%b d=%h done=%b stall=%b sum=%h we=%b", bus0.dbg_valid, bus0.dbg_rdata,
               bus0.done, bus0.cpu_stall, bus0.checksum, bus0.imem_we);
    end
    step();
    n_checks++;
    if (bus0.dbg_valid !== 1'b0 || bus0.dbg_rdata !== 32'(prev) + 32'd1) begin
      n_fail++;
      $display("FAIL b2b_hold got v=%b d=%h", bus0.dbg_valid, bus0.dbg_rdata);
    end
  endtask

  task automatic test_dbg_during_copy();
    run_copy("dbg_in_copy", 3, 5'd5, -1, 1'b0);
  endtask

  task automatic test_restart();
    run_copy("restart", $urandom_range(1, 30), AW'($urandom_range(0, 30)), -1, 1'b0);
  endtask

  task automatic test_start_with_dbg();
    reset = 1'b1;
    step();
    reset = 1'b0;
    run_copy("start_dbg", -1, AW'($urandom_range(0, 30)), $urandom_range(2, 32), 1'b1);
  endtask

  task automatic test_reset_mid_copy();
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    for (int c = 1; c < 10; c++) step();
    n_checks++;
    if (bus0.imem_we !== 1'b1 || bus0.imem_waddr !== 5'd8) begin
      n_fail++;
      $display("FAIL midcopy_pre got we=%b a=%0d exp we=1 a=8", bus0.imem_we, bus0.imem_waddr);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (bus0.imem_we !== 1'b0 || bus0.done !== 1'b0 || bus0.cpu_stall !== 1'b1 || bus0.checksum !== '0) begin
      n_fail++;
      $display("FAIL midcopy_reset got we=%b done=%b stall=%b sum=%h", bus0.imem_we, bus0.done,
               bus0.cpu_stall, bus0.checksum);
    end
    for (int i = 0; i < 35; i++) step();
    n_checks++;
    if (bus0.imem_we !== 1'b0 || bus0.done !== 1'b0 || bus0.cpu_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL midcopy_no_done got we=%b done=%b stall=%b", bus0.imem_we, bus0.done, bus0.cpu_stall);
    end
    run_copy("after_reset", -1, '0, -1, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    bus0.start    = 1'b0;
    bus0.dbg_req  = 1'b0;
    bus0.dbg_addr = '0;
    bus4.start    = 1'b0;
    bus4.dbg_req  = 1'b0;
    bus4.dbg_addr = '0;
    test_reset();
    test_basic_copy();
    test_base_offset();
    test_back_to_back();
    test_dbg_during_copy();
    test_restart();
    test_start_with_dbg();
    test_reset_mid_copy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
